imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Boot sequencer for the ARM single-cycle processor's instruction memory.
- Holds the CPU in reset while it receives a program image as a byte stream (from the UART/debug peripheral).
- Assembles little-endian 32-bit words and writes them sequentially into the instruction memory write port.
- Releases the CPU once the image is complete and valid; a reload request repeats the sequence at any time.

Parameters:
- DEPTH, 256, instruction memory depth in 32-bit words.
- AW, 8, word-address width; must equal clog2(DEPTH).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- byte_valid  input  1  source has a byte on byte_data.
- byte_data  input  8  image byte.
- byte_ready  output  1  loader accepts a byte this cycle; transfer occurs when byte_valid and byte_ready are both high.
- reload  input  1  single-cycle request to restart loading.
- imem_we  output  1  instruction memory write strobe, one cycle per word.
- imem_wa  output  AW  word address of the write.
- imem_wd  output  32  write data.
- cpu_reset  output  1  holds the processor in reset while high.
- done  output  1  image loaded, CPU running.
- error  output  1  load aborted; sticky until reset or reload.

Behaviour:
- Reset values: byte_ready=0, imem_we=0, imem_wa=0, imem_wd=0, cpu_reset=1, done=0, error=0. FSM enters CNT_LO on the first clock after reset deasserts.
- Image format:
  - word count N, 16-bit little-endian (2 bytes);
  - N words of 4 bytes each, least-significant byte first;
  - one checksum byte (only when the optional feature is enabled).
- byte_ready=1 only in CNT_LO, CNT_HI, DATA and CSUM; 0 in all other states.
- States and transitions:
  - CNT_LO: on transfer, latch count[7:0] -> CNT_HI.
  - CNT_HI: on transfer, latch count[15:8], then evaluate:
    - N > DEPTH -> ERR;
    - N = 0 -> CSUM if feature enabled, else RUN;
    - otherwise DATA with byte_idx=0, word_idx=0.
  - DATA: on transfer, shift byte into word_buf[8*byte_idx +: 8] and increment byte_idx (2-bit). When the 4th byte is accepted -> WRITE.
  - WRITE (exactly 1 cycle): imem_we=1, imem_wa=word_idx, imem_wd=assembled word; word_idx increments. If word_idx+1 = N -> CSUM (feature enabled) or RUN; else -> DATA.
  - CSUM: on transfer, compare the byte with the running checksum. Match -> RUN; mismatch -> ERR.
  - RUN: cpu_reset=0, done=1.
  - ERR: cpu_reset=1, error=1, byte_ready=0.
- Latency:
  - 5 cycles minimum per word (4 byte transfers + 1 write cycle).
  - cpu_reset falls the cycle after entering RUN (registered output).
- Back-pressure: byte_valid low stalls the FSM indefinitely with no timeout; all state is held.
- reload:
  - Any state except CNT_LO: next state CNT_LO; cpu_reset=1, done=0, error=0.
  - Any partially assembled word is discarded; imem_we is never asserted in the cycle reload is sampled.
  - reload in CNT_LO is ignored.
  - reload has priority over a simultaneous byte transfer; that byte is dropped (byte_ready is forced low that cycle).
- Asynchronous reset mid-load: all outputs return to reset values immediately. Words already written remain in memory; the image is reloaded from scratch.
- word_idx wraps never: N ≤ DEPTH is guaranteed by the CNT_HI check. N = DEPTH writes addresses 0..DEPTH-1.
- imem_wa and imem_wd are held stable outside WRITE cycles.

Optional Feature:
- Macro: IMEM_BOOT_CHECKSUM_EN.
- Defined:
  - Running checksum is the XOR of all count and data bytes, cleared on entry to CNT_LO.
  - The trailing CSUM byte is required; a mismatch -> ERR with the CPU held in reset.
- Not defined:
  - The CSUM state and checksum register are absent.
  - The FSM goes directly to RUN after the last WRITE (or after CNT_HI when N=0); no trailing byte is consumed.

Test Plan:
- Reset, then send count 02 00, bytes 04 00 A0 E3, 08 10 A0 E3 -> write 0xE3A00004 at wa=0 and 0xE3A01008 at wa=1. cpu_reset falls and done=1 after the final byte (checksum 0x02^0x04^0xA0^0xE3^0x08^0x10^0xA0^0xE3=0x1E when the feature is enabled).
- Count 01 01 (N=257) -> error=1, cpu_reset=1, byte_ready=0, no imem_we pulses.
- Checksum enabled, N=1, correct data, wrong checksum byte 0x00 -> error=1, done=0. Then reload plus a valid image -> done=1, error=0.
- Insert 10 idle cycles (byte_valid=0) between each byte of a 1-word image -> identical write result; imem_we pulses exactly once.
- Pulse reload after 2 data bytes of word 0 -> no write occurs, cpu_reset stays 1. A fresh image then loads correctly at wa=0.
- Count 00 00 -> done=1 with no imem_we (feature off); with the feature on, checksum byte 0x00 is required.

Source files
------------

// File: rtl/imem_boot_loader.sv
// ============================================================================
// Module   : imem_boot_loader
// Brief    : Streams a byte-wise program image into instruction memory and
//            holds the CPU in reset until the image is complete.
//            Optional trailing XOR checksum: define IMEM_BOOT_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imem_boot_loader #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    input  logic          reload,
    output logic          imem_we,
    output logic [AW-1:0] imem_wa,
    output logic [31:0]   imem_wd,
    output logic          cpu_reset,
    output logic          done,
    output logic          error
);

    typedef enum logic [2:0] {
`ifdef IMEM_BOOT_CHECKSUM_EN
        CSUM   = 3'd7,
`endif
        INIT   = 3'd0,
        CNT_LO = 3'd1,
        CNT_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        RUN    = 3'd5,
        ERR    = 3'd6
    } state_t;

    // State reached once the last word (or an empty image) has been written.
`ifdef IMEM_BOOT_CHECKSUM_EN
    localparam state_t C_TAIL_STATE = CSUM;
`else
    localparam state_t C_TAIL_STATE = RUN;
`endif

    localparam logic [16:0] C_DEPTH = 17'(DEPTH);

    state_t       r_state;
    state_t       w_next_state;

    logic [15:0]  r_count;
    logic [15:0]  r_word_idx;
    logic [1:0]   r_byte_idx;
    logic [31:0]  r_word_buf;
    logic [AW-1:0] r_wa;
    logic [31:0]  r_wd;
    logic         r_cpu_reset;
    logic         r_done;
    logic         r_error;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0]   r_csum;
`endif

    logic         w_reload;
    logic         w_xfer;
    logic [15:0]  w_count_full;
    logic         w_last_word;

    // reload is meaningless while already waiting for the first count byte.
    assign w_reload     = reload && (r_state != CNT_LO);
    assign w_xfer       = byte_valid && byte_ready;
    assign w_count_full = {byte_data, r_count[7:0]};
    assign w_last_word  = ((r_word_idx + 16'd1) == r_count);

    assign imem_wa   = r_wa;
    assign imem_wd   = r_wd;
    assign cpu_reset = r_cpu_reset;
    assign done      = r_done;
    assign error     = r_error;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        byte_ready   = 1'b0;
        imem_we      = 1'b0;
        case (r_state)
            INIT: begin
                w_next_state = CNT_LO;
            end
            CNT_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    w_next_state = CNT_HI;
                end
            end
            CNT_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    if ({1'b0, w_count_full} > C_DEPTH) begin
                        w_next_state = ERR;
                    end else if (w_count_full == 16'd0) begin
                        w_next_state = C_TAIL_STATE;
                    end else begin
                        w_next_state = DATA;
                    end
                end
            end
            DATA: begin
                byte_ready = 1'b1;
                if (byte_valid && (r_byte_idx == 2'd3)) begin
                    w_next_state = WRITE;
                end
            end
            WRITE: begin
                imem_we      = 1'b1;
                w_next_state = w_last_word ? C_TAIL_STATE : DATA;
            end
`ifdef IMEM_BOOT_CHECKSUM_EN
            CSUM: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    w_next_state = (byte_data == r_csum) ? RUN : ERR;
                end
            end
`endif
            RUN: begin
                w_next_state = RUN;
            end
            ERR: begin
                w_next_state = ERR;
            end
            default: begin
                w_next_state = INIT;
            end
        endcase
        // reload wins over any concurrent byte or write.
        if (w_reload) begin
            w_next_state = CNT_LO;
            byte_ready   = 1'b0;
            imem_we      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count    <= 16'd0;
            r_word_idx <= 16'd0;
            r_byte_idx <= 2'd0;
            r_word_buf <= 32'd0;
            r_wa       <= '0;
            r_wd       <= 32'd0;
        end else begin
            if (w_xfer) begin
                case (r_state)
                    CNT_LO: begin
                        r_count[7:0] <= byte_data;
                    end
                    CNT_HI: begin
                        r_count[15:8] <= byte_data;
                        r_byte_idx    <= 2'd0;
                        r_word_idx    <= 16'd0;
                    end
                    DATA: begin
                        r_word_buf[{r_byte_idx, 3'b000} +: 8] <= byte_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        // Write port registers only move when a word completes.
                        if (r_byte_idx == 2'd3) begin
                            r_wa <= r_word_idx[AW-1:0];
                            r_wd <= {byte_data, r_word_buf[23:0]};
                        end
                    end
                    default: begin
                    end
                endcase
            end
            if (imem_we) begin
                r_word_idx <= r_word_idx + 16'd1;
            end
            if (w_reload) begin
                r_byte_idx <= 2'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_cpu_reset <= !((r_state == RUN) && !w_reload);
            r_done      <= (r_state == RUN) && !w_reload;
            r_error     <= (r_state == ERR) && !w_reload;
        end
    end

`ifdef IMEM_BOOT_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_csum <= 8'd0;
        end else if ((w_next_state == CNT_LO) && (r_state != CNT_LO)) begin
            r_csum <= 8'd0;
        end else if (w_xfer && (r_state != CSUM)) begin
            r_csum <= r_csum ^ byte_data;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
// ============================================================================
// Module   : tb_imem_boot_loader
// Brief    : Scoreboard bench for imem_boot_loader; expected memory writes are
//            queued by the stimulus and popped by an independent monitor.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_imem_boot_loader;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          reload;
    logic          imem_we;
    logic [AW-1:0] imem_wa;
    logic [31:0]   imem_wd;
    logic          cpu_reset;
    logic          done;
    logic          error;

    imem_boot_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_wa    (imem_wa),
        .imem_wd    (imem_wd),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] wa;
        logic [31:0]   wd;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_writes = 0;
    int         w_before;
    logic [7:0] tb_csum;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got wa=0x%h wd=0x%h, expected no write", imem_wa, imem_wd);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", 32'(imem_wa), 32'(mon_e.wa));
                check("write_data", imem_wd, mon_e.wd);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int waits;
        waits = 0;
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!byte_ready) begin
            check("byte_ready_timeout", 32'(byte_ready), 32'd1);
        end else begin
            tb_csum = tb_csum ^ b;
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_count(input logic [15:0] n);
        tb_csum = 8'h00;
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic send_csum();
`ifdef IMEM_BOOT_CHECKSUM_EN
        send_byte(tb_csum);
`endif
    endtask

    task automatic expect_write(input logic [AW-1:0] wa, input logic [31:0] wd);
        wr_t e;
        e.wa = wa;
        e.wd = wd;
        exp_q.push_back(e);
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    // Waits (bounded) for the status outputs to settle, then compares them.
    task automatic expect_status(input string name, input logic d, input logic e, input logic c);
        int waits;
        waits = 0;
        @(negedge clk);
        while (!(done === d && error === e && cpu_reset === c) && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        check({name, "_done"}, 32'(done), 32'(d));
        check({name, "_error"}, 32'(error), 32'(e));
        check({name, "_cpu_reset"}, 32'(cpu_reset), 32'(c));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        reload     = 1'b0;
        tb_csum    = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_wa", 32'(imem_wa), 32'd0);
        check("rst_imem_wd", imem_wd, 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        reset = 1'b0;

        // Two-word image (checksum 0x1E when enabled).
        w_before = n_writes;
        expect_write(8'd0, 32'hE3A00004);
        expect_write(8'd1, 32'hE3A01008);
        send_count(16'd2);
        send_word(32'hE3A00004);
        send_word(32'hE3A01008);
        send_csum();
        expect_status("two_word", 1'b1, 1'b0, 1'b0);
        check("two_word_writes", 32'(n_writes - w_before), 32'd2);
        check("hold_wa", 32'(imem_wa), 32'd1);
        check("hold_wd", imem_wd, 32'hE3A01008);

        // Oversized count: N = 257.
        pulse_reload();
        expect_status("reload1", 1'b0, 1'b0, 1'b1);
        w_before = n_writes;
        send_count(16'd257);
        expect_status("too_big", 1'b0, 1'b1, 1'b1);
        check("too_big_ready", 32'(byte_ready), 32'd0);
        check("too_big_writes", 32'(n_writes - w_before), 32'd0);

`ifdef IMEM_BOOT_CHECKSUM_EN
        // Bad checksum, then recovery with a valid image.
        pulse_reload();
        expect_status("reload_c", 1'b0, 1'b0, 1'b1);
        expect_write(8'd0, 32'hE3A00004);
        send_count(16'd1);
        send_word(32'hE3A00004);
        send_byte(8'h00);
        expect_status("bad_csum", 1'b0, 1'b1, 1'b1);
        pulse_reload();
        expect_write(8'd0, 32'hE3A00004);
        send_count(16'd1);
        send_word(32'hE3A00004);
        send_csum();
        expect_status("good_csum", 1'b1, 1'b0, 1'b0);
`endif

        // One-word image with long idle gaps between bytes.
        pulse_reload();
        w_before = n_writes;
        expect_write(8'd0, 32'h12345678);
        send_count(16'd1);
        repeat (10) @(negedge clk);
        send_byte(8'h78);
        repeat (10) @(negedge clk);
        send_byte(8'h56);
        repeat (10) @(negedge clk);
        send_byte(8'h34);
        repeat (10) @(negedge clk);
        send_byte(8'h12);
        repeat (10) @(negedge clk);
        send_csum();
        expect_status("idle_gap", 1'b1, 1'b0, 1'b0);
        check("idle_gap_writes", 32'(n_writes - w_before), 32'd1);

        // Reload mid-word discards the partial word.
        pulse_reload();
        w_before = n_writes;
        send_count(16'd2);
        send_byte(8'hAA);
        send_byte(8'hBB);
        pulse_reload();
        expect_status("mid_reload", 1'b0, 1'b0, 1'b1);
        check("mid_reload_writes", 32'(n_writes - w_before), 32'd0);
        expect_write(8'd0, 32'hDEADBEEF);
        send_count(16'd1);
        send_word(32'hDEADBEEF);
        send_csum();
        expect_status("fresh", 1'b1, 1'b0, 1'b0);
        check("fresh_wd", imem_wd, 32'hDEADBEEF);

        // Asynchronous reset acts without waiting for a clock edge.
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_done", 32'(done), 32'd0);
        check("async_cpu_reset", 32'(cpu_reset), 32'd1);
        check("async_wd", imem_wd, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Empty image.
        w_before = n_writes;
        send_count(16'd0);
        send_csum();
        expect_status("empty", 1'b1, 1'b0, 1'b0);
        check("empty_writes", 32'(n_writes - w_before), 32'd0);

        // Full-depth image: addresses 0..DEPTH-1.
        pulse_reload();
        w_before = n_writes;
        send_count(16'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0]  b;
            logic [31:0] w;
            b = 8'(i);
            w = {~b, b ^ 8'hAA, b ^ 8'h55, b};
            expect_write(8'(i), w);
            send_word(w);
        end
        send_csum();
        expect_status("full", 1'b1, 1'b0, 1'b0);
        check("full_writes", 32'(n_writes - w_before), 32'(DEPTH));
        check("full_last_wa", 32'(imem_wa), 32'(DEPTH - 1));

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
